// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: baud table, bit-period
// helper, FSM state encoding, parity sense constants and the per-frame config.
package uart_pkg;

   localparam int unsigned NUM_BAUD = 12;
   localparam int unsigned DATA_W   = 8;

   // Parity sense as carried on the ohel input
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   // Line settings captured when a byte leaves the FIFO
   typedef struct packed {
      logic [3:0] baud_sel;
      logic       eight;
      logic       pen;
      logic       ohel;
   } frame_cfg_t;

   // Baud rate for a selector; codes above the table saturate at 921600
   function automatic int unsigned baud_rate(input logic [3:0] sel);
      int unsigned rate;
      case (sel)
         4'd0:    rate = 300;
         4'd1:    rate = 1_200;
         4'd2:    rate = 2_400;
         4'd3:    rate = 4_800;
         4'd4:    rate = 9_600;
         4'd5:    rate = 19_200;
         4'd6:    rate = 38_400;
         4'd7:    rate = 57_600;
         4'd8:    rate = 115_200;
         4'd9:    rate = 230_400;
         4'd10:   rate = 460_800;
         default: rate = 921_600;
      endcase
      return rate;
   endfunction

   // Clocks per bit; never less than one so the bit timer always advances
   function automatic int unsigned bit_ticks(input int unsigned clk_hz, input logic [3:0] sel);
      int unsigned ticks;
      ticks = clk_hz / baud_rate(sel);
      return (ticks == 32'd0) ? 32'd1 : ticks;
   endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous FIFO with registered head, count and flags.
//  clk, rst        clock, async active-high reset (flushes pointers/count)
//  push, push_data write request; ignored while full
//  pop             read request; ignored while empty
//  head            registered copy of the oldest entry
//  count           occupied entries (0..DEPTH)
//  full, empty     registered count decodes
//  low             registered count <= LOW_LEVEL
module sync_fifo #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned LOW_LEVEL = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     low
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr, rd_ptr_d;
   logic [CNT_W-1:0] count_d;
   logic [WIDTH-1:0] head_d;
   logic             push_ok_c;
   logic             pop_ok_c;

   // Accept decisions use registered flags only
   always_comb begin
      push_ok_c = push && !full;
      pop_ok_c  = pop && !empty;
      wr_ptr_d  = push_ok_c ? wr_ptr + PTR_W'(1) : wr_ptr;
      rd_ptr_d  = pop_ok_c  ? rd_ptr + PTR_W'(1) : rd_ptr;
      count_d   = count;
      case ({push_ok_c, pop_ok_c})
         2'b10:   count_d = count + CNT_W'(1);
         2'b01:   count_d = count - CNT_W'(1);
         default: count_d = count;
      endcase
      // New head is the byte being written when the queue drains to it this cycle
      if (push_ok_c && (wr_ptr == rd_ptr_d)) begin
         head_d = push_data;
      end else begin
         head_d = mem[rd_ptr_d];
      end
   end

   // Storage has no reset; only pointers and count define contents
   always_ff @(posedge clk) begin
      if (push_ok_c) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         low    <= 1'b1;
      end else begin
         wr_ptr <= wr_ptr_d;
         rd_ptr <= rd_ptr_d;
         count  <= count_d;
         head   <= head_d;
         full   <= (count_d == CNT_W'(DEPTH));
         empty  <= (count_d == '0);
         low    <= (count_d <= CNT_W'(LOW_LEVEL));
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes pushed by the CPU are queued and sent
// back-to-back as start + 7/8 data (LSB first) + optional parity + stop.
//  clk, rst          clock, async active-high reset (abandons any frame)
//  baud_sel          baud code, latched per frame
//  eight, pen, ohel  data length, parity enable, parity sense (1 = odd); latched per frame
//  wr_en, wr_data    one-cycle push strobe and byte
//  clr_ovf           clears sticky overflow (a same-cycle rejected write wins)
//  tx                registered serial line, idle high
//  fifo_count, full, empty  FIFO occupancy
//  busy              transmitter not idle
//  overflow          sticky: write attempted while full
//  tx_int            level: fifo_count <= LOW_WM
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned LOW_WM     = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [3:0]                    baud_sel,
   input  logic                          eight,
   input  logic                          pen,
   input  logic                          ohel,
   input  logic                          wr_en,
   input  logic [7:0]                    wr_data,
   input  logic                          clr_ovf,
   output logic                          tx,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          full,
   output logic                          empty,
   output logic                          busy,
   output logic                          overflow,
   output logic                          tx_int
);

   // Slowest baud code sets the timer width
   localparam int unsigned TIMER_W = $clog2(bit_ticks(CLK_HZ, 4'd0) + 32'd1);

   tx_state_t          state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]  shift_q, shift_d;
   logic               parity_q, parity_d;
   frame_cfg_t         cfg_q, cfg_d;
   logic               tx_d;
   logic               busy_d;
   logic               overflow_d;
   logic               pop_c;
   logic               load_c;
   logic               bit_done_c;
   logic [DATA_W-1:0]  head;
   logic [DATA_W-1:0]  data_c;
   logic [TIMER_W-1:0] reload_cur_c;
   logic [TIMER_W-1:0] reload_tbl [16];

   // Per-code bit timer reload values, fixed at elaboration
   for (genvar g = 0; g < 16; g++) begin : g_reload
      assign reload_tbl[g] = TIMER_W'(bit_ticks(CLK_HZ, 4'(g)) - 32'd1);
   end

   sync_fifo #(
      .WIDTH     (DATA_W),
      .DEPTH     (FIFO_DEPTH),
      .LOW_LEVEL (LOW_WM)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (pop_c),
      .head      (head),
      .count     (fifo_count),
      .full      (full),
      .empty     (empty),
      .low       (tx_int)
   );

   // Next-state and datapath for the frame sequencer
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      cfg_d        = cfg_q;
      tx_d         = tx;
      pop_c        = 1'b0;
      load_c       = 1'b0;
      bit_done_c   = (timer_q == '0);
      reload_cur_c = reload_tbl[cfg_q.baud_sel];
      data_c       = eight ? head : {1'b0, head[6:0]};

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               load_c = 1'b1;
            end
         end

         ST_START: begin
            if (bit_done_c) begin
               state_d   = ST_DATA;
               timer_d   = reload_cur_c;
               tx_d      = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = 3'd0;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end

         ST_DATA: begin
            if (bit_done_c) begin
               timer_d = reload_cur_c;
               if (bit_cnt_q == (cfg_q.eight ? 3'd7 : 3'd6)) begin
                  if (cfg_q.pen) begin
                     state_d = ST_PARITY;
                     tx_d    = parity_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
               end
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end

         ST_PARITY: begin
            if (bit_done_c) begin
               state_d = ST_STOP;
               timer_d = reload_cur_c;
               tx_d    = 1'b1;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end

         ST_STOP: begin
            if (bit_done_c) begin
               if (!empty) begin
                  load_c = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // Pop the head and start a frame with the settings present right now
      if (load_c) begin
         pop_c          = 1'b1;
         state_d        = ST_START;
         tx_d           = 1'b0;
         shift_d        = data_c;
         cfg_d.baud_sel = baud_sel;
         cfg_d.eight    = eight;
         cfg_d.pen      = pen;
         cfg_d.ohel     = ohel;
         timer_d        = reload_tbl[baud_sel];
         parity_d       = (ohel == PAR_EVEN) ? ^data_c : ~^data_c;
      end

      busy_d = (state_d != ST_IDLE);

      // Rejected write takes priority over clear
      overflow_d = overflow;
      if (wr_en && full) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         cfg_q     <= '0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         cfg_q     <= cfg_d;
         tx        <= tx_d;
         busy      <= busy_d;
         overflow  <= overflow_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: line waveform compared against a
// bit-level frame model, plus FIFO/flag/reset checks.
module tb_uart_tx_buffered;

   localparam int unsigned CLK_HZ = 1_152_000;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned LOW_WM = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] baud_sel;
   logic       eight, pen, ohel;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       clr_ovf;
   logic       tx;
   logic [4:0] fifo_count;
   logic       full, empty, busy, overflow, tx_int;

   int n_assert = 0;
   int n_fail   = 0;

   logic wave[$];
   logic exp_wave[$];
   bit   rec_on = 1'b0;

   int baud_tbl [12] = '{300, 1200, 2400, 4800, 9600, 19200, 38400, 57600,
                         115200, 230400, 460800, 921600};

   uart_tx_buffered #(
      .CLK_HZ     (CLK_HZ),
      .FIFO_DEPTH (DEPTH),
      .LOW_WM     (LOW_WM)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .baud_sel   (baud_sel),
      .eight      (eight),
      .pen        (pen),
      .ohel       (ohel),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .clr_ovf    (clr_ovf),
      .tx         (tx),
      .fifo_count (fifo_count),
      .full       (full),
      .empty      (empty),
      .busy       (busy),
      .overflow   (overflow),
      .tx_int     (tx_int)
   );

   always #5 clk = ~clk;

   // Line recorder, one sample per clock away from the active edge
   always @(negedge clk) begin
      if (rec_on) wave.push_back(tx);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ticks_of(input int sel);
      int s;
      int t;
      s = (sel > 11) ? 11 : sel;
      t = CLK_HZ / baud_tbl[s];
      return (t < 1) ? 1 : t;
   endfunction

   // Reference frame: each line bit held for t clocks
   function automatic void add_frame(input logic [7:0] d, input bit e8, input bit p,
                                     input bit o, input int t);
      int   nb;
      int   ones;
      logic b;
      nb   = e8 ? 8 : 7;
      ones = 0;
      repeat (t) exp_wave.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         b = d[i];
         if (b) ones++;
         repeat (t) exp_wave.push_back(b);
      end
      if (p) begin
         b = (((ones + (o ? 1 : 0)) % 2) == 1);
         repeat (t) exp_wave.push_back(b);
      end
      repeat (t) exp_wave.push_back(1'b1);
   endfunction

   // Align on first low sample, compare frames, then require an idle tail
   task automatic compare_wave(input string tag, input int tail);
      int   start;
      int   mism;
      int   idx;
      logic e;
      start = -1;
      for (int i = 0; i < wave.size(); i++) begin
         if (wave[i] === 1'b0) begin
            start = i;
            break;
         end
      end
      mism = 0;
      if (start < 0) begin
         mism = exp_wave.size() + tail;
      end else begin
         for (int i = 0; i < exp_wave.size() + tail; i++) begin
            e   = (i < exp_wave.size()) ? exp_wave[i] : 1'b1;
            idx = start + i;
            if (idx >= wave.size()) mism++;
            else if (wave[idx] !== e) mism++;
         end
      end
      chk(tag, 32'(mism), 32'd0);
   endtask

   task automatic start_rec();
      wave.delete();
      exp_wave.delete();
      rec_on = 1'b1;
   endtask

   task automatic set_cfg(input bit e8, input bit p, input bit o, input logic [3:0] sel);
      eight    = e8;
      pen      = p;
      ohel     = o;
      baud_sel = sel;
   endtask

   // One-cycle push; returns 1ns after the capturing edge
   task automatic write_byte(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic wait_count(input string tag, input int target, input int budget);
      int n;
      n = 0;
      while (fifo_count !== 5'(target) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(fifo_count), 32'(target));
   endtask

   task automatic send_frame(input string tag, input logic [7:0] d, input bit e8,
                             input bit p, input bit o, input logic [3:0] sel);
      @(negedge clk);
      set_cfg(e8, p, o, sel);
      start_rec();
      write_byte(d);
      @(negedge clk);
      @(negedge clk);
      wait_idle({tag, "_idle"}, 2000);
      repeat (5) @(negedge clk);
      rec_on = 1'b0;
      add_frame(d, e8, p, o, ticks_of(int'(sel)));
      compare_wave(tag, 4);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b0;
      logic [7:0] burst [17];
      logic [7:0] d;
      bit         e8, p, o;
      logic [3:0] sel;

      rst      = 1'b1;
      wr_en    = 1'b0;
      wr_data  = 8'h00;
      clr_ovf  = 1'b0;
      set_cfg(1'b1, 1'b0, 1'b0, 4'd8);

      // Reset values, both during and after reset
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_int", 32'(tx_int), 32'd1);
      chk("rst_count", 32'(fifo_count), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_tx", 32'(tx), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // 0xA5, 8 data bits, even parity: latency and full frame
      @(negedge clk);
      set_cfg(1'b1, 1'b1, 1'b0, 4'd8);
      start_rec();
      write_byte(8'hA5);
      @(negedge clk);
      chk("a5_count_k", 32'(fifo_count), 32'd1);
      chk("a5_tx_k", 32'(tx), 32'd1);
      chk("a5_busy_k", 32'(busy), 32'd0);
      @(negedge clk);
      chk("a5_tx_k1", 32'(tx), 32'd0);
      chk("a5_busy_k1", 32'(busy), 32'd1);
      chk("a5_count_k1", 32'(fifo_count), 32'd0);
      wait_idle("a5_idle", 400);
      repeat (5) @(negedge clk);
      rec_on = 1'b0;
      add_frame(8'hA5, 1'b1, 1'b1, 1'b0, 10);
      chk("a5_len", 32'(exp_wave.size()), 32'd110);
      compare_wave("a5_wave", 4);

      // 7-bit frames; bit 7 of the written byte must not appear
      send_frame("c1_7n1", 8'hC1, 1'b0, 1'b0, 1'b0, 4'd8);
      send_frame("41_7o1", 8'h41, 1'b0, 1'b1, 1'b1, 4'd8);

      // Random single frames over several baud codes
      for (int i = 0; i < 6; i++) begin
         d   = 8'($urandom);
         e8  = 1'($urandom);
         p   = 1'($urandom);
         o   = 1'($urandom);
         sel = 4'(6 + ($urandom % 4));
         send_frame($sformatf("rnd%0d", i), d, e8, p, o, sel);
      end

      // Burst fill to full, overflow handling, watermark, contiguous drain
      @(negedge clk);
      set_cfg(1'b1, 1'b0, 1'b0, 4'd8);
      start_rec();
      b0 = 8'($urandom);
      for (int i = 0; i < 17; i++) burst[i] = 8'($urandom);
      write_byte(b0);
      for (int i = 0; i < 17; i++) begin
         wr_en   = 1'b1;
         wr_data = burst[i];
         @(posedge clk);
         #1;
         if (i == 15) begin
            chk("burst_count16", 32'(fifo_count), 32'd16);
            chk("burst_full", 32'(full), 32'd1);
            chk("burst_ovf_pre", 32'(overflow), 32'd0);
            chk("burst_int_hi", 32'(tx_int), 32'd0);
         end
      end
      wr_en = 1'b0;
      chk("burst_count_drop", 32'(fifo_count), 32'd16);
      chk("burst_ovf_set", 32'(overflow), 32'd1);
      wr_en   = 1'b1;
      clr_ovf = 1'b1;
      @(posedge clk);
      #1;
      chk("ovf_set_wins", 32'(overflow), 32'd1);
      wr_en = 1'b0;
      @(posedge clk);
      #1;
      clr_ovf = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);
      wait_count("wm_count5", 5, 3000);
      chk("wm_int_at5", 32'(tx_int), 32'd0);
      wait_count("wm_count4", 4, 300);
      chk("wm_int_at4", 32'(tx_int), 32'd1);
      wait_idle("burst_idle", 1000);
      repeat (5) @(negedge clk);
      rec_on = 1'b0;
      add_frame(b0, 1'b1, 1'b0, 1'b0, 10);
      for (int i = 0; i < 16; i++) add_frame(burst[i], 1'b1, 1'b0, 1'b0, 10);
      compare_wave("burst_wave", 4);

      // Settings changed mid-frame apply to the following frame only
      @(negedge clk);
      set_cfg(1'b1, 1'b0, 1'b0, 4'd8);
      start_rec();
      b0 = 8'h3C;
      d  = 8'hD2;
      write_byte(b0);
      write_byte(d);
      repeat (30) @(negedge clk);
      set_cfg(1'b0, 1'b1, 1'b1, 4'd9);
      wait_idle("cfg_idle", 1000);
      repeat (5) @(negedge clk);
      rec_on = 1'b0;
      add_frame(b0, 1'b1, 1'b0, 1'b0, 10);
      add_frame(d, 1'b0, 1'b1, 1'b1, 5);
      compare_wave("cfg_wave", 4);

      // Asynchronous reset in the middle of a data bit with bytes queued
      @(negedge clk);
      set_cfg(1'b1, 1'b0, 1'b0, 4'd8);
      write_byte(8'h00);
      write_byte(8'h11);
      write_byte(8'h22);
      write_byte(8'h33);
      repeat (25) @(negedge clk);
      chk("mid_count3", 32'(fifo_count), 32'd3);
      chk("mid_busy", 32'(busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_tx", 32'(tx), 32'd1);
      chk("arst_count", 32'(fifo_count), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      start_rec();
      repeat (300) @(negedge clk);
      rec_on = 1'b0;
      exp_wave.delete();
      for (int i = 0; i < 300; i++) exp_wave.push_back(1'b1);
      begin
         int lows;
         lows = 0;
         foreach (wave[i]) if (wave[i] !== 1'b1) lows++;
         chk("post_arst_quiet", 32'(lows), 32'd0);
      end
      chk("post_arst_busy", 32'(busy), 32'd0);
      chk("post_arst_count", 32'(fifo_count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
